// File: rtl/avalon_regif.sv
// avalon_regif: Avalon-MM style slave front end for a flat register file.
//
// A write is captured in IDLE and presented to the register file for one
// cycle (WRITE) as regbus/regbe plus a one-hot activ strobe. A read is
// captured in IDLE, waits RD_LAT-1 cycles in READ, and returns data in DONE
// with readdatavalid. The read data is taken from regr during DONE. Bad
// addresses and simultaneous read/write strobes set the sticky err flag.
//
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   address, cs,        CPU request: word address, chip select,
//   read_n, write_n     active-low read/write strobes
//   writedata,          write data and byte lanes
//   byteenable
//   err_clr             clears err (a simultaneous set event wins)
//   regr                packed register read-back, word k at k*DATA_W
//   readdata,           read data (zero unless readdatavalid)
//   readdatavalid
//   waitrequest         high whenever the block is not in IDLE
//   regbus, regbe       captured write data / byte enables (held)
//   activ               one-hot write strobes, high only in WRITE
//   err                 sticky error flag
module avalon_regif #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_REGS  = 21,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ID_ADDR   = 31,
  parameter logic [15:0] SYSTEM_ID = 16'hCA05
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       cs,
  input  logic                       read_n,
  input  logic                       write_n,
  input  logic [DATA_W-1:0]          writedata,
  input  logic [DATA_W/8-1:0]        byteenable,
  input  logic                       err_clr,
  input  logic [NUM_REGS*DATA_W-1:0] regr,
  output logic [DATA_W-1:0]          readdata,
  output logic                       readdatavalid,
  output logic                       waitrequest,
  output logic [DATA_W-1:0]          regbus,
  output logic [DATA_W/8-1:0]        regbe,
  output logic [NUM_REGS-1:0]        activ,
  output logic                       err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cnt;
  logic [31:0]       addr_ext;
  logic              addr_ok;
  logic              rd_req;
  logic              wr_req;
  logic              err_set;
  logic [DATA_W-1:0] rd_sel;

  assign rd_req   = cs & ~read_n;
  assign wr_req   = cs & ~write_n;
  assign addr_ext = 32'(addr_q);
  assign addr_ok  = addr_ext < NUM_REGS;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_req && !rd_req)
          state_nxt = WRITE;
        else if (rd_req && !wr_req)
          state_nxt = (RD_LAT == 1) ? DONE : READ;
      end
      WRITE: state_nxt = IDLE;
      READ:  if (cnt == 2'(RD_LAT - 2)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign err_set = (state == IDLE  && rd_req && wr_req) ||
                   (state == WRITE && !addr_ok) ||
                   (state == DONE  && !addr_ok && addr_ext != ID_ADDR);

  // regbus/regbe are loaded on the accept edge so they are valid for the
  // whole WRITE cycle and simply hold afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt    <= '0;
      regbus <= '0;
      regbe  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (wr_req && !rd_req) begin
            addr_q <= address;
            regbus <= writedata;
            regbe  <= byteenable;
          end else if (rd_req && !wr_req) begin
            addr_q <= address;
            cnt    <= '0;
          end
        end
        READ:    cnt <= cnt + 2'd1;
        default: ;
      endcase
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++)
      if (addr_ext == k) rd_sel = regr[k*DATA_W +: DATA_W];
    if (addr_ext == ID_ADDR) rd_sel = DATA_W'(SYSTEM_ID);
  end

  always_comb begin
    activ = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++)
      activ[k] = (state == WRITE) && (addr_ext == k);
  end

  assign readdatavalid = (state == DONE);
  assign readdata      = (state == DONE) ? rd_sel : '0;
  assign waitrequest   = (state != IDLE);

endmodule

// File: doc/avalon_regif.md
AVALON_REGIF -- requirements
Module: avalon_regif

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  16  data bus width; multiple of 8.
  ADDR_W  5  word address width.
  NUM_REGS  21  number of mapped registers; 1..2**ADDR_W-1.
  RD_LAT  1  read latency in cycles, from acceptance to readdatavalid; 1..3.
  ID_ADDR  31  address returning SYSTEM_ID; must be >= NUM_REGS.
  SYSTEM_ID  16'hCA05  hardware ID; zero-extended to DATA_W.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock  in  1  single clock; all state changes on the rising edge.
  reset  in  1  asynchronous, active-low reset.
  address  in  ADDR_W  word address.
  cs  in  1  chip select.
  read_n  in  1  read strobe, active-low.
  write_n  in  1  write strobe, active-low.
  writedata  in  DATA_W  CPU write data.
  byteenable  in  DATA_W/8  write byte lanes.
  err_clr  in  1  clears err.
  regr  in  NUM_REGS*DATA_W  register read-back; register k occupies bits k*DATA_W+:DATA_W.
  readdata  out  DATA_W  read data.
  readdatavalid  out  1  read data strobe.
  waitrequest  out  1  block busy; request not accepted.
  regbus  out  DATA_W  internal write bus.
  regbe  out  DATA_W/8  registered byte enables.
  activ  out  NUM_REGS  one-hot write strobes.
  err  out  1  sticky error flag.

Function
REQ-003 Decode: rd_req = cs & ~read_n; wr_req = cs & ~write_n.
REQ-004 The FSM SHALL have exactly the states IDLE, WRITE, READ and DONE.
REQ-005 A request SHALL be accepted only in IDLE; waitrequest SHALL be 0 in IDLE and 1 in every other state.
REQ-006 IDLE with wr_req & ~rd_req: capture address, writedata and byteenable; go to WRITE.
REQ-007 WRITE, one cycle: regbus = captured data; regbe = captured byte enables; activ[addr] = 1 if addr < NUM_REGS, otherwise all zero and err set; then go to IDLE.
- Back-to-back writes therefore take 2 cycles each.
REQ-008 IDLE with rd_req & ~wr_req: capture address; go to READ; stay in READ for RD_LAT-1 cycles (0 cycles if RD_LAT = 1); then go to DONE.
REQ-009 DONE, one cycle: readdatavalid = 1; readdata = selected value; then go to IDLE.
- Selected value: regr word addr if addr < NUM_REGS; SYSTEM_ID if addr = ID_ADDR; otherwise 0 and err set.
- Read latency is exactly RD_LAT cycles from the accept edge to the readdatavalid cycle.
REQ-010 The selected value SHALL be taken from regr during the DONE cycle, not at acceptance.
REQ-011 readdata SHALL be 0 whenever readdatavalid = 0.
REQ-012 activ SHALL be all zero outside WRITE; at most one activ bit SHALL be high in any cycle.
REQ-013 regbus and regbe SHALL hold their last value outside WRITE.
REQ-014 rd_req & wr_req in IDLE: no transfer performed; err set; remain in IDLE.
REQ-015 Deasserting cs, read_n or write_n after acceptance SHALL NOT abort the transfer.
REQ-016 err SHALL be sticky; err_clr clears it; a set event in the same cycle as err_clr wins.
REQ-017 Requests presented while waitrequest = 1 SHALL be ignored; the master must hold them until accepted.

Reset
REQ-018 reset = 0 SHALL asynchronously force:
- FSM to IDLE;
- readdata, readdatavalid, regbus, regbe, activ and err to 0;
- waitrequest to 0.
REQ-019 Reset during WRITE or READ SHALL drop the transfer: no activ pulse and no readdatavalid after release.
REQ-020 The first request SHALL be accepted on the first rising edge after reset release.

Verification
REQ-021 Write addr 3, data 16'h1234, be 2'b11 -> next cycle activ = 21'h8, regbus = 16'h1234, waitrequest = 1; cycle after that activ = 0.
REQ-022 RD_LAT = 2, regr word 5 = 16'hBEEF, read addr 5 -> readdatavalid exactly 2 cycles after accept with readdata = 16'hBEEF; readdata = 0 in every other cycle.
REQ-023 Read addr 31 -> 16'hCA05, err stays 0; read addr 25 -> 0 and err = 1; err_clr -> err = 0.
REQ-024 Read and write strobes asserted together at addr 2 -> no activ and no readdatavalid; err = 1.
REQ-025 Reset asserted while in READ -> all outputs 0 immediately; no readdatavalid after release; a write on the first edge after release is accepted.
